// File: rtl/covariance_outer_product.sv
// Upper-triangular conjugate product generator: one captured snapshot of CHANNELS complex
// samples becomes PAIR_COUNT beats of x_i*conj(x_j), i<=j, in row-major pair order.
module covariance_outer_product #(
  parameter int CHANNELS       = 4,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int PRODUCT_WIDTH  = 2*SAMPLE_WIDTH+1,
  parameter int PAIR_COUNT     = CHANNELS*(CHANNELS+1)/2,
  parameter int PAIR_IDX_WIDTH = $clog2(PAIR_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS*2*SAMPLE_WIDTH-1:0]   s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic [2*PRODUCT_WIDTH-1:0]           m_axis_tdata,
  output logic [PAIR_IDX_WIDTH-1:0]            m_axis_tuser,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [0:0]                           dbg_state
);

  // Handshakes: a beat transfers on a clock edge where valid && ready are both high.
  // Once valid is raised, data/user/last hold until that transfer happens.

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int VEC_W = CHANNELS*2*SAMPLE_WIDTH;
  localparam int EXT_W = PRODUCT_WIDTH - SAMPLE_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CH_W-1:0]           LAST_CH  = CH_W'(CHANNELS-1);
  localparam logic [PAIR_IDX_WIDTH-1:0] LAST_IDX = PAIR_IDX_WIDTH'(PAIR_COUNT-1);

  logic [0:0]                  state_q, state_d;
  logic [VEC_W-1:0]            vec_q, vec_d;
  logic [CH_W-1:0]             i_q, i_d, j_q, j_d;
  logic [PAIR_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [2*PRODUCT_WIDTH-1:0]  tdata_q, tdata_d;
  logic [PAIR_IDX_WIDTH-1:0]   tuser_q, tuser_d;
  logic                        tlast_q, tlast_d;
  logic                        tvalid_q, tvalid_d;

  logic signed [SAMPLE_WIDTH-1:0]  ch_re [CHANNELS];
  logic signed [SAMPLE_WIDTH-1:0]  ch_im [CHANNELS];
  logic signed [PRODUCT_WIDTH-1:0] a_ext, b_ext, c_ext, d_ext;
  logic signed [PRODUCT_WIDTH-1:0] prod_re, prod_im;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch_re[k] = vec_q[k*2*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign ch_im[k] = vec_q[k*2*SAMPLE_WIDTH+SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  // Operands are widened before multiplying so the sum of two full-scale products fits.
  always_comb begin
    a_ext   = {{EXT_W{ch_re[i_q][SAMPLE_WIDTH-1]}}, ch_re[i_q]};
    b_ext   = {{EXT_W{ch_im[i_q][SAMPLE_WIDTH-1]}}, ch_im[i_q]};
    c_ext   = {{EXT_W{ch_re[j_q][SAMPLE_WIDTH-1]}}, ch_re[j_q]};
    d_ext   = {{EXT_W{ch_im[j_q][SAMPLE_WIDTH-1]}}, ch_im[j_q]};
    prod_re = a_ext*c_ext + b_ext*d_ext;
    prod_im = b_ext*c_ext - a_ext*d_ext;
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    i_d      = i_q;
    j_d      = j_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (state_q == IDLE) begin
      if (tvalid_q && m_axis_tready) begin
        tvalid_d = 1'b0;
      end
      if (s_axis_tvalid) begin
        vec_d   = s_axis_tdata;
        i_d     = '0;
        j_d     = '0;
        idx_d   = '0;
        state_d = RUN;
      end
    end else if (!tvalid_q || m_axis_tready) begin
      tdata_d  = {prod_im, prod_re};
      tuser_d  = idx_q;
      tlast_d  = (idx_q == LAST_IDX);
      tvalid_d = 1'b1;
      idx_d    = idx_q + 1'b1;
      if (j_q == LAST_CH) begin
        i_d = i_q + 1'b1;
        j_d = i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      idx_q    <= '0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      i_q      <= i_d;
      j_q      <= j_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s_axis_tready = (state_q == IDLE) && !rst;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_covariance_outer_product.sv
// Bench for covariance_outer_product: scenario tasks drive snapshots, a queue holds the
// expected beats computed from a wide-integer model, and each task compares beats inline.
module tb_covariance_outer_product;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int PW  = 2*W+1;
  localparam int PC  = N*(N+1)/2;
  localparam int PIW = $clog2(PC);
  localparam int VW  = N*2*W;
  localparam int BW  = 2*PW+PIW+1;

  logic           clk = 1'b0;
  logic           rst;
  logic [VW-1:0]  s_tdata;
  logic           s_tvalid;
  logic           s_tready;
  logic [2*PW-1:0] m_tdata;
  logic [PIW-1:0] m_tuser;
  logic           m_tlast;
  logic           m_tvalid;
  logic           m_tready;
  logic [0:0]     dbg_state;

  logic [BW-1:0]  exp_q[$];
  int             total = 0;
  int             bad   = 0;

  always #5 clk = ~clk;

  covariance_outer_product #(.CHANNELS(N), .SAMPLE_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .dbg_state     (dbg_state)
  );

  function automatic logic [2*W-1:0] cx(input int re, input int im);
    return {im[W-1:0], re[W-1:0]};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*2*W +: 2*W] = $urandom();
    return v;
  endfunction

  // Expected beats {tlast, tuser, imag, real} for one accepted snapshot.
  task automatic push_snapshot(input logic [VW-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i; j < N; j++) begin
        longint a, b, c, d, re, im;
        logic [PW-1:0] re_b, im_b;
        a = longint'($signed(v[i*2*W +: W]));
        b = longint'($signed(v[i*2*W+W +: W]));
        c = longint'($signed(v[j*2*W +: W]));
        d = longint'($signed(v[j*2*W+W +: W]));
        re = a*c + b*d;
        im = b*c - a*d;
        re_b = re[PW-1:0];
        im_b = im[PW-1:0];
        exp_q.push_back({(idx == PC-1) ? 1'b1 : 1'b0, PIW'(idx), im_b, re_b});
        idx++;
      end
    end
  endtask

  // Samples the cycle's handshakes with inputs already set, then moves to the next sample point.
  task automatic step(output logic fired, output logic [BW-1:0] beat, output logic acc);
    #1;
    fired = m_tvalid && m_tready;
    beat  = {m_tlast, m_tuser, m_tdata};
    acc   = s_tvalid && s_tready;
    if (acc) push_snapshot(s_tdata);
    @(negedge clk);
  endtask

  task automatic send(input logic [VW-1:0] v, output logic ok);
    logic f, a;
    logic [BW-1:0] b;
    ok = 1'b0;
    s_tdata  = v;
    s_tvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      step(f, b, a);
      ok = a;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    logic f, a;
    logic [BW-1:0] b;
    rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = '0;
    step(f, b, a);
    step(f, b, a);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    total++; if (m_tuser !== '0) begin bad++; $display("FAIL reset_tuser got=%0d want=0", m_tuser); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_tlast); end
    total++; if (m_tdata !== '0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_tdata); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_stready got=%b want=0", s_tready); end
    rst = 1'b0;
    step(f, b, a);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL release_stready got=%b want=1", s_tready); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL release_state got=%b want=0", dbg_state); end
  endtask

  task automatic test_basic;
    int spec_idx[6] = '{0, 1, 2, 3, 4, 9};
    int spec_re[6]  = '{5, 1, 0, -4, 10, 16};
    int spec_im[6]  = '{0, 7, 0, -8, 0, 0};
    logic f, a, ok;
    logic [BW-1:0] b, e;
    int n, first;
    m_tready = 1'b1;
    send({cx(-4, 0), cx(0, 0), cx(3, -1), cx(1, 2)}, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b want=1", ok); end
    n = 0; first = -1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step(f, b, a);
      if (f) begin
        if (first < 0) first = c;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL basic_beat got=%h want=%h", b, e); end
        for (int k = 0; k < 6; k++) begin
          if (int'(b[2*PW +: PIW]) == spec_idx[k]) begin
            total++;
            if (b[2*PW-1:0] !== {PW'(spec_im[k]), PW'(spec_re[k])}) begin
              bad++; $display("FAIL basic_idx%0d got=%h want=%h", spec_idx[k], b[2*PW-1:0],
                              {PW'(spec_im[k]), PW'(spec_re[k])});
            end
          end
        end
        n++;
      end
    end
    total++; if (first !== 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", first); end
    total++; if (n !== PC) begin bad++; $display("FAIL basic_count got=%0d want=%0d", n, PC); end
  endtask

  task automatic test_extremes;
    logic f, a, ok;
    logic [BW-1:0] b, e;
    logic [PW-1:0] big;
    big = 33'd2147483648;
    m_tready = 1'b1;
    send({N{cx(-32768, -32768)}}, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ext_accept got=%b want=1", ok); end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step(f, b, a);
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL ext_beat got=%h want=%h", b, e); end
        total++;
        if (b[2*PW-1:0] !== {{PW{1'b0}}, big}) begin
          bad++; $display("FAIL ext_value got=%h want=%h", b[2*PW-1:0], {{PW{1'b0}}, big});
        end
      end
    end
    send({cx(0, 0), cx(0, 0), cx(32767, -32768), cx(-32768, 32767)}, ok);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step(f, b, a);
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL ext2_beat got=%h want=%h", b, e); end
        if (b[2*PW +: PIW] == PIW'(1)) begin
          total++;
          if (b[2*PW-1:0] !== {PW'(-65535), PW'(-2147418112)}) begin
            bad++; $display("FAIL ext2_idx1 got=%h want=%h", b[2*PW-1:0],
                            {PW'(-65535), PW'(-2147418112)});
          end
        end
      end
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ext_drain left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    logic f, a, ok, seen9, prev_stall, done_stall, vld;
    logic [BW-1:0] b, e, prev_beat;
    int stall_left;
    m_tready = 1'b1;
    send(rand_vec(), ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b want=1", ok); end
    seen9 = 1'b0; prev_stall = 1'b0; done_stall = 1'b0; stall_left = 0; prev_beat = '0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      #1;
      if (m_tvalid && m_tuser == PIW'(PC-1)) seen9 = 1'b1;
      total++; if (s_tready !== seen9) begin bad++; $display("FAIL bp_stready got=%b want=%b", s_tready, seen9); end
      if (prev_stall) begin
        total++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, prev_beat}) begin
          bad++; $display("FAIL bp_hold got=%h want=%h", {m_tlast, m_tuser, m_tdata}, prev_beat);
        end
      end
      if (!done_stall && m_tvalid && m_tuser == PIW'(3)) begin
        done_stall = 1'b1; stall_left = 5;
      end
      if (stall_left > 0) begin
        m_tready = 1'b0; stall_left--;
      end else if (done_stall) begin
        m_tready = 1'($urandom_range(0, 1));
      end else begin
        m_tready = 1'b1;
      end
      vld = m_tvalid;
      step(f, b, a);
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL bp_beat got=%h want=%h", b, e); end
      end
      prev_stall = vld && !f;
      prev_beat  = b;
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_drain left=%0d want=0", exp_q.size()); end
    m_tready = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic f, a, bubble;
    logic [BW-1:0] b, e;
    int acc_cnt, last_acc, beats;
    m_tready = 1'b1; s_tdata = rand_vec(); s_tvalid = 1'b1;
    acc_cnt = 0; last_acc = 0; beats = 0; bubble = 1'b0;
    for (int c = 0; c < 100 && (acc_cnt < 3 || exp_q.size() > 0); c++) begin
      if (bubble) begin
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%b want=0", m_tvalid); end
        bubble = 1'b0;
      end
      step(f, b, a);
      if (a) begin
        if (acc_cnt > 0) begin
          total++;
          if (c - last_acc != PC+1) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", c - last_acc, PC+1); end
        end
        last_acc = c; acc_cnt++;
        if (acc_cnt == 3) s_tvalid = 1'b0;
        s_tdata = rand_vec();
      end
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL b2b_beat got=%h want=%h", b, e); end
        beats++;
        if (b[2*PW +: PIW] == PIW'(PC-1)) bubble = 1'b1;
      end
    end
    s_tvalid = 1'b0;
    total++; if (beats !== 3*PC) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", beats, 3*PC); end
  endtask

  task automatic test_reset_mid;
    logic f, a, ok, found;
    logic [BW-1:0] b, e;
    m_tready = 1'b1;
    send(rand_vec(), ok);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      step(f, b, a);
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL rmid_beat got=%h want=%h", b, e); end
        if (b[2*PW +: PIW] == PIW'(4)) found = 1'b1;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rmid_beat4 got=%b want=1", found); end
    rst = 1'b1; m_tready = 1'b0;
    step(f, b, a);
    exp_q.delete();
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_tvalid got=%b want=0", m_tvalid); end
    total++; if (m_tuser !== '0) begin bad++; $display("FAIL rmid_tuser got=%0d want=0", m_tuser); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL rmid_tlast got=%b want=0", m_tlast); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rmid_stready got=%b want=0", s_tready); end
    rst = 1'b0; m_tready = 1'b1;
    step(f, b, a);
    send(rand_vec(), ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_accept got=%b want=1", ok); end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step(f, b, a);
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL rmid_new got=%h want=%h", b, e); end
      end
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rmid_drain left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_busy_change;
    logic f, a, ok;
    logic [BW-1:0] b, e;
    m_tready = 1'b1;
    send(rand_vec(), ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL busy_accept got=%b want=1", ok); end
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      s_tdata  = rand_vec();
      m_tready = 1'($urandom_range(0, 1));
      step(f, b, a);
      if (f) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {BW{1'bx}};
        total++; if (b !== e) begin bad++; $display("FAIL busy_beat got=%h want=%h", b, e); end
      end
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL busy_drain left=%0d want=0", exp_q.size()); end
    m_tready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_busy_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
